// File: rtl/sprite_palette_banked.sv
// Multi-bank runtime-writable sprite palette with registered lookup,
// frame-synchronous bank switching, hit-flash and transparency flag.
module sprite_palette_banked #(
    parameter int IDX_W        = 4,
    parameter int BANKS        = 4,
    parameter int COLOR_W      = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 6,
    localparam int BW          = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int RGB_W       = 3 * COLOR_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [IDX_W-1:0]   pix_index,
    input  logic [BW-1:0]      bank_req,
    input  logic               wr_en,
    input  logic [BW-1:0]      wr_bank,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [RGB_W-1:0]   wr_rgb,
    input  logic               flash_trig,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               pix_transp,
    output logic               rgb_valid,
    output logic [BW-1:0]      active_bank,
    output logic               flash_active
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [BW:0]      BANKS_L  = BANKS[BW:0];
    localparam logic [IDX_W-1:0] TRANSP_L = TRANSP_IDX[IDX_W-1:0];
    localparam logic [7:0]       FLASH_L  = FLASH_FRAMES[7:0];

    logic [RGB_W-1:0] r_pal [BANKS][ENTRIES];
    logic [RGB_W-1:0] r_rgb;
    logic             r_transp;
    logic             r_valid;
    logic [BW-1:0]    r_bank;
    logic [7:0]       r_fc;

    logic             w_wr_ok;
    logic             w_req_ok;
    logic             w_transp;
    logic [RGB_W-1:0] w_entry;

    assign w_wr_ok  = wr_en && ({1'b0, wr_bank} < BANKS_L);
    assign w_req_ok = {1'b0, bank_req} < BANKS_L;
    assign w_transp = (pix_index == TRANSP_L);
    assign w_entry  = r_pal[r_bank][pix_index];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int b = 0; b < BANKS; b++)
                for (int e = 0; e < ENTRIES; e++)
                    r_pal[b][e] <= '0;
        end else if (w_wr_ok) begin
            r_pal[wr_bank][wr_index] <= wr_rgb;
        end
    end

    // Flash only whitens opaque pixels, using the counter as seen this edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rgb    <= '0;
            r_transp <= 1'b0;
            r_valid  <= 1'b0;
        end else if (pix_valid) begin
            r_valid  <= 1'b1;
            r_transp <= w_transp;
            r_rgb    <= (r_fc[0] && !w_transp) ? {RGB_W{1'b1}} : w_entry;
        end else begin
            r_valid  <= 1'b0;
            r_transp <= 1'b0;
            r_rgb    <= '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_bank <= '0;
        end else if (frame_start && w_req_ok) begin
            r_bank <= bank_req;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fc <= '0;
        end else if (flash_trig) begin
            r_fc <= FLASH_L;
        end else if (frame_start && (r_fc != 8'd0)) begin
            r_fc <= r_fc - 8'd1;
        end
    end

    assign {red, green, blue} = r_rgb;
    assign pix_transp         = r_transp;
    assign rgb_valid          = r_valid;
    assign active_bank        = r_bank;
    assign flash_active       = (r_fc != 8'd0);

endmodule
